mem_port_arbiter: RTL

// - Shares one 128-bit line-wide memory bus between the fetch-stage instruction port and the data port.
// - Instruction-side requests use the cyc/stb strobe pair; data-side requests use the same protocol.
// - Sits between the pipeline/L1 ports and the physical memory/L2.
// - Runs one outstanding transaction at a time. Latches the winning request, drives the bus, then returns read data and a one-cycle resp to the winner.

---
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_port_arbiter                                             |
// | Description : Shares one line-wide memory bus between the fetch-stage      |
// |               instruction port and the data port. One transaction is in   |
// |               flight at a time: the winning request is latched onto the    |
// |               mem_* bus, held until mem_ack, and the read line plus a      |
// |               one-cycle resp pulse are returned to the winner.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, rst                         clock, synchronous active-high reset    |
// |   imem_cyc/stb/address             instruction read request                |
// |   imem_rdata, imem_resp            instruction read line, completion pulse |
// |   dmem_cyc/stb/we/sel/address/wdata data read/write request                |
// |   dmem_rdata, dmem_resp            data read line, completion pulse        |
// |   mem_cyc/stb/we/sel/address/wdata downstream bus request (registered)     |
// |   mem_rdata, mem_ack               downstream read line and completion     |
// +----------------------------------------------------------------------------+
// | Configuration                                                              |
// |   ARB_ROUND_ROBIN_EN  defined   : ties go to the port not granted last     |
// |                       undefined : fixed priority, dmem wins every tie      |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128,
    parameter int SEL_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    // instruction port
    input  logic              imem_cyc,
    input  logic              imem_stb,
    input  logic [ADDR_W-1:0] imem_address,
    output logic [LINE_W-1:0] imem_rdata,
    output logic              imem_resp,
    // data port
    input  logic              dmem_cyc,
    input  logic              dmem_stb,
    input  logic              dmem_we,
    input  logic [SEL_W-1:0]  dmem_sel,
    input  logic [ADDR_W-1:0] dmem_address,
    input  logic [LINE_W-1:0] dmem_wdata,
    output logic [LINE_W-1:0] dmem_rdata,
    output logic              dmem_resp,
    // downstream memory bus
    output logic              mem_cyc,
    output logic              mem_stb,
    output logic              mem_we,
    output logic [SEL_W-1:0]  mem_sel,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_I_BUSY = 2'd1;
    localparam logic [1:0] c_ST_D_BUSY = 2'd2;
    localparam logic [1:0] c_ST_RESP   = 2'd3;

    logic [1:0]        r_state;
    logic              r_mem_cyc;
    logic              r_mem_stb;
    logic              r_mem_we;
    logic [SEL_W-1:0]  r_mem_sel;
    logic [ADDR_W-1:0] r_mem_address;
    logic [LINE_W-1:0] r_mem_wdata;
    logic [LINE_W-1:0] r_imem_rdata;
    logic              r_imem_resp;
    logic [LINE_W-1:0] r_dmem_rdata;
    logic              r_dmem_resp;

    logic w_imem_req;
    logic w_dmem_req;
    logic w_grant_d;

    assign w_imem_req = imem_cyc & imem_stb;
    assign w_dmem_req = dmem_cyc & dmem_stb;

`ifdef ARB_ROUND_ROBIN_EN
    // 0 = instruction port was granted last, 1 = data port was granted last.
    logic r_rr_last_d;

    // On a tie, the port that did not win last time goes first.
    assign w_grant_d = w_dmem_req & (~w_imem_req | ~r_rr_last_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_last_d <= 1'b0;
        end else if ((r_state == c_ST_IDLE) && (w_imem_req || w_dmem_req)) begin
            r_rr_last_d <= w_grant_d;
        end
    end
`else
    assign w_grant_d = w_dmem_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_mem_cyc     <= 1'b0;
            r_mem_stb     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_sel     <= '0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_imem_rdata  <= '0;
            r_imem_resp   <= 1'b0;
            r_dmem_rdata  <= '0;
            r_dmem_resp   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant_d) begin
                        r_state       <= c_ST_D_BUSY;
                        r_mem_cyc     <= 1'b1;
                        r_mem_stb     <= 1'b1;
                        r_mem_we      <= dmem_we;
                        r_mem_sel     <= dmem_sel;
                        r_mem_address <= dmem_address;
                        r_mem_wdata   <= dmem_wdata;
                    end else if (w_imem_req) begin
                        // Instruction fetches are always full-line reads.
                        r_state       <= c_ST_I_BUSY;
                        r_mem_cyc     <= 1'b1;
                        r_mem_stb     <= 1'b1;
                        r_mem_we      <= 1'b0;
                        r_mem_sel     <= '1;
                        r_mem_address <= imem_address;
                        r_mem_wdata   <= '0;
                    end
                end
                c_ST_I_BUSY: begin
                    if (mem_ack) begin
                        r_state      <= c_ST_RESP;
                        r_mem_cyc    <= 1'b0;
                        r_mem_stb    <= 1'b0;
                        r_imem_rdata <= mem_rdata;
                        r_imem_resp  <= 1'b1;
                    end
                end
                c_ST_D_BUSY: begin
                    if (mem_ack) begin
                        r_state     <= c_ST_RESP;
                        r_mem_cyc   <= 1'b0;
                        r_mem_stb   <= 1'b0;
                        r_dmem_resp <= 1'b1;
                        // A write completion leaves the last read line in place.
                        if (!r_mem_we) begin
                            r_dmem_rdata <= mem_rdata;
                        end
                    end
                end
                c_ST_RESP: begin
                    // Requests are not sampled here, so a requester still
                    // holding stb through its resp is not granted again.
                    r_state     <= c_ST_IDLE;
                    r_imem_resp <= 1'b0;
                    r_dmem_resp <= 1'b0;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign mem_cyc     = r_mem_cyc;
    assign mem_stb     = r_mem_stb;
    assign mem_we      = r_mem_we;
    assign mem_sel     = r_mem_sel;
    assign mem_address = r_mem_address;
    assign mem_wdata   = r_mem_wdata;
    assign imem_rdata  = r_imem_rdata;
    assign imem_resp   = r_imem_resp;
    assign dmem_rdata  = r_dmem_rdata;
    assign dmem_resp   = r_dmem_resp;

endmodule
`default_nettype wire
